tdl_window_monitor: RTL
=======================

# tdl_window_monitor

Sequencer and statistics engine for the TDL voltage-glitch sensor. After the sensor has been calibrated, the top-level FSM arms this block around a protected operation such as an AES run. The block then waits for the popcount pipeline to settle, samples the 7-bit ones-count once per cycle over a programmable window, and classifies each sample against a glitch threshold. It returns a single result record over a valid/ready handshake, and pulses a recalibration request when the window shows baseline drift with no glitch.

## Interface
- QW, 7, width of the TDL ones-count
- CW, 16, width of window length, hit counter and timestamp
- SETTLE, 4, cycles discarded after arming (count_ones pipeline flush); legal range 1..15
- clk  in  1  sensor clock (tdl_in domain); all logic on its rising edge
- reset  in  1  synchronous, active-high; one clock, one reset
- start  in  1  one-cycle arm pulse; honoured only in IDLE
- abort  in  1  return to IDLE from any state; no result produced
- thresh  in  QW  glitch threshold; a sample is a glitch when q_count <= thresh
- q_nom  in  QW  nominal calibrated count
- q_tol  in  QW  drift tolerance around q_nom
- win_len  in  CW  samples per window; 0 is treated as 1
- q_count  in  QW  ones-count from count_ones, one new value per cycle
- busy  out  1  high in every state except IDLE
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accepts record
- res_glitch  out  1  at least one glitch sample in the window
- res_min  out  QW  minimum sampled count
- res_max  out  QW  maximum sampled count
- res_first  out  CW  0-based index of the first glitch sample; all-ones if none
- res_hits  out  CW  number of glitch samples, saturating at all-ones
- drift_req  out  1  one-cycle pulse, see Operation

## Operation
- States: IDLE, SETTLE, SAMPLE, REPORT.
- IDLE -> SETTLE on start. On this transition:
  - latch thresh, q_nom, q_tol and win_len; later changes to these inputs are ignored until the next start;
  - load settle counter = SETTLE-1;
  - clear accumulators: min=all-ones, max=0, hits=0, first=all-ones, glitch=0, idx=0.
- SETTLE: q_count is ignored. Decrement the settle counter; at 0, go to SAMPLE.
- SAMPLE: each cycle, process q_count:
  - update min and max;
  - if q_count <= thresh_l: set glitch, increment hits (saturating), and load first=idx if first is still all-ones;
  - idx increments every sample cycle;
  - the sample with idx == max(win_len_l,1)-1 is the last one, and the FSM goes to REPORT on the next edge.
- Result registers are copied from the accumulators on entry to REPORT.
- REPORT: res_valid=1. On res_valid & res_ready, go to IDLE with res_valid=0 on the next cycle. The result registers hold their values until the next REPORT entry.
- Drift check on REPORT entry, using 8-bit arithmetic:
  - lo = q_nom - q_tol, saturating at 0;
  - hi = q_nom + q_tol, saturating at 2^QW-1;
  - drift_req pulses for exactly one cycle if glitch==0 and (max < lo or min > hi).
- abort:
  - has priority over start and every transition;
  - next state is IDLE with res_valid=0;
  - result registers are not updated and drift_req is not pulsed.
- If start and abort are asserted in the same cycle in IDLE, the block stays in IDLE.
- start is ignored outside IDLE, including during REPORT.

## Timing
- Reset values: state=IDLE, busy=0, res_valid=0, res_glitch=0, res_min=0, res_max=0, res_first=all-ones, res_hits=0, drift_req=0.
- Reset mid-operation behaves identically to reset from IDLE.
- Start to first sampled value: start at cycle T puts the block in SETTLE from T+1, and q_count is first sampled in cycle T+1+SETTLE.
- Last sample to result: the last sample at cycle S gives res_valid=1 and drift_req (if any) at S+1.
- Handshake:
  - res_valid is held until accepted;
  - a handshake in cycle R gives busy=0 at R+1;
  - the next start is accepted at R+1 at the earliest.
- Total window occupancy: start to res_valid is 1 + SETTLE + max(win_len,1) cycles.
- All outputs are registered; there is no combinational path from an input to an output.

## Test plan
- SETTLE=4, win_len=8, thresh=15, q_count=40 constant -> res_valid 13 cycles after start; glitch=0, min=max=40, hits=0, first=0xFFFF; with q_nom=40, q_tol=3, no drift_req.
- Same setup, q_count=12 at sample indices 3 and 4 (all others 40) -> glitch=1, min=12, max=40, hits=2, first=3.
- win_len=0, q_count=10, thresh=10 -> exactly one sample; hits=1, first=0 (checks the equality boundary).
- Drift: q_count=50 constant, q_nom=40, q_tol=3 -> drift_req one cycle wide, coincident with the rising edge of res_valid. Repeat with q_nom=2, q_tol=5 -> lo saturates at 0 and drift_req still fires.
- res_ready held low for 20 cycles -> res_valid and the result fields stay stable, and a start pulse during that time is ignored. Then assert res_ready -> busy=0 on the next cycle.
- Abort in SAMPLE at index 5 -> IDLE on the next cycle, res_valid never asserts, previous result registers unchanged. Repeat the scenario with reset instead of abort -> all outputs return to their reset values.

Source files
------------

// File: rtl/tdl_window_monitor.sv
// -----------------------------------------------------------------------------
// tdl_window_monitor
//
// Sequencer and statistics engine for the TDL voltage-glitch sensor.
//
// Operation: once armed, the block
//   1. discards SETTLE cycles while the popcount pipeline flushes,
//   2. samples q_count once per cycle over a programmable window,
//   3. returns one result record over a valid/ready handshake.
// A one-cycle drift_req pulse is raised when the window contains no glitch
// but lies entirely outside the calibrated nominal band.
//
// Parameters
//   QW      width of the TDL ones-count
//   CW      width of window length, hit counter and first-glitch index
//   SETTLE  cycles discarded after arming (1..15)
//
// Ports
//   clk, reset          sensor clock; synchronous active-high reset
//   start, abort        arm pulse (IDLE only) / unconditional return to IDLE
//   thresh              glitch when q_count <= thresh
//   q_nom, q_tol        nominal count and drift tolerance
//   win_len             samples per window (0 is treated as 1)
//   q_count             ones-count, one new value per cycle
//   busy                high in every state except IDLE
//   res_valid/res_ready result handshake
//   res_glitch          at least one glitch sample in the window
//   res_min, res_max    minimum / maximum sampled count
//   res_first           index of first glitch sample, all-ones if none
//   res_hits            glitch sample count, saturating
//   drift_req           one-cycle recalibration request
// -----------------------------------------------------------------------------
module tdl_window_monitor #(
    parameter int QW     = 7,
    parameter int CW     = 16,
    parameter int SETTLE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [QW-1:0] thresh,
    input  logic [QW-1:0] q_nom,
    input  logic [QW-1:0] q_tol,
    input  logic [CW-1:0] win_len,
    input  logic [QW-1:0] q_count,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_glitch,
    output logic [QW-1:0] res_min,
    output logic [QW-1:0] res_max,
    output logic [CW-1:0] res_first,
    output logic [CW-1:0] res_hits,
    output logic          drift_req
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_REPORT
    } state_t;

    localparam logic [QW-1:0] Q_ONES      = '1;
    localparam logic [CW-1:0] C_ONES      = '1;
    localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE - 1);

    state_t state, state_next;
    logic   arm;

    // Configuration captured at arm time.
    logic [QW-1:0] thresh_l, q_nom_l, q_tol_l;
    logic [CW-1:0] win_len_l;

    logic [3:0]    settle_cnt;

    // Running accumulators and their values after folding in this cycle's sample.
    logic [QW-1:0] acc_min, acc_max, upd_min, upd_max;
    logic [CW-1:0] acc_first, acc_hits, upd_first, upd_hits, idx;
    logic          acc_glitch, upd_glitch, is_glitch;

    logic [CW-1:0] win_last;
    logic          last_sample, enter_report;

    // Drift band, one bit wider than the count so sum/difference cannot wrap.
    logic [QW:0]   band_sum, band_lo, band_hi;
    logic          drift_hit;

    assign win_last    = (win_len_l == '0) ? '0 : win_len_l - 1'b1;
    assign last_sample = (idx == win_last);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // ------------------------------------------------------------------------
    // FSM: next state. abort overrides everything, including a same-cycle start.
    // ------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        arm        = 1'b0;
        unique case (state)
            ST_IDLE:   if (start) begin
                           state_next = ST_SETTLE;
                           arm        = 1'b1;
                       end
            ST_SETTLE: if (settle_cnt == '0) state_next = ST_SAMPLE;
            ST_SAMPLE: if (last_sample)      state_next = ST_REPORT;
            ST_REPORT: if (res_ready)        state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
            arm        = 1'b0;
        end
    end

    assign enter_report = (state == ST_SAMPLE) && (state_next == ST_REPORT);

    // ------------------------------------------------------------------------
    // Sample classification and accumulator update
    // ------------------------------------------------------------------------
    always_comb begin
        is_glitch  = (q_count <= thresh_l);
        upd_min    = (q_count < acc_min) ? q_count : acc_min;
        upd_max    = (q_count > acc_max) ? q_count : acc_max;
        upd_glitch = acc_glitch | is_glitch;
        upd_hits   = acc_hits;
        upd_first  = acc_first;
        if (is_glitch) begin
            if (acc_hits != C_ONES)  upd_hits  = acc_hits + 1'b1;
            if (acc_first == C_ONES) upd_first = idx;
        end
    end

    // Drift band with saturation at both ends.
    always_comb begin
        band_sum  = {1'b0, q_nom_l} + {1'b0, q_tol_l};
        band_hi   = (band_sum > {1'b0, Q_ONES}) ? {1'b0, Q_ONES} : band_sum;
        band_lo   = (q_nom_l >= q_tol_l) ? {1'b0, q_nom_l - q_tol_l} : '0;
        drift_hit = !upd_glitch &&
                    (({1'b0, upd_max} < band_lo) || ({1'b0, upd_min} > band_hi));
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            thresh_l   <= '0;
            q_nom_l    <= '0;
            q_tol_l    <= '0;
            win_len_l  <= '0;
            settle_cnt <= '0;
            acc_min    <= Q_ONES;
            acc_max    <= '0;
            acc_first  <= C_ONES;
            acc_hits   <= '0;
            acc_glitch <= 1'b0;
            idx        <= '0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_glitch <= 1'b0;
            res_min    <= '0;
            res_max    <= '0;
            res_first  <= C_ONES;
            res_hits   <= '0;
            drift_req  <= 1'b0;
        end else begin
            // Status outputs follow the next state so they change with it.
            busy      <= (state_next != ST_IDLE);
            res_valid <= (state_next == ST_REPORT);
            drift_req <= enter_report && drift_hit;

            if (arm) begin
                thresh_l   <= thresh;
                q_nom_l    <= q_nom;
                q_tol_l    <= q_tol;
                win_len_l  <= win_len;
                settle_cnt <= SETTLE_LOAD;
                acc_min    <= Q_ONES;
                acc_max    <= '0;
                acc_first  <= C_ONES;
                acc_hits   <= '0;
                acc_glitch <= 1'b0;
                idx        <= '0;
            end

            if (state == ST_SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;

            if (state == ST_SAMPLE) begin
                acc_min    <= upd_min;
                acc_max    <= upd_max;
                acc_first  <= upd_first;
                acc_hits   <= upd_hits;
                acc_glitch <= upd_glitch;
                idx        <= idx + 1'b1;
            end

            // Results include the last sample, so copy the updated values.
            if (enter_report) begin
                res_glitch <= upd_glitch;
                res_min    <= upd_min;
                res_max    <= upd_max;
                res_first  <= upd_first;
                res_hits   <= upd_hits;
            end
        end
    end

endmodule
